wb_gpio_bank: RTL and testbench
===============================

WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 16, LED output count (1..32).
REQ-002 SHALL have parameter NUM_SW, default 16, switch input count (1..32).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required before the debounced switch value updates (>=1).
REQ-004 SHALL have ports: i_clk in 1 clock; i_reset in 1 sync active-high reset.
REQ-005 SHALL have ports: i_wb_cyc, i_wb_stb, i_wb_we in 1 each; i_wb_addr in 30; i_wb_data in 32; i_wb_sel in 4 (pipelined Wishbone slave).
REQ-006 SHALL have ports: o_wb_ack out 1; o_wb_stall out 1; o_wb_data out 32.
REQ-007 SHALL have ports: i_switches in NUM_SW, asynchronous; o_leds out NUM_LEDS; o_irq out 1, level interrupt.
REQ-008 Reset i_reset, synchronous, active-high; clock i_clk.

Function
REQ-009 o_wb_stall SHALL be constant 0; a request is accepted every cycle i_wb_cyc && i_wb_stb.
REQ-010 Each accepted request SHALL produce exactly one o_wb_ack, registered, one cycle later; back-to-back requests give back-to-back acks.
REQ-011 If i_wb_cyc is low in the ack cycle, o_wb_ack SHALL be 0 and the pending ack is dropped.
REQ-012 o_wb_data SHALL be registered at accept, valid only while o_wb_ack=1, and 0 otherwise.
REQ-013 Decode SHALL use i_wb_addr[2:0]; upper bits ignored. Map: 0 LED_OUT RW; 1 LED_SET W1S; 2 LED_CLR W1C; 3 SW_IN RO; 4 EDGE_STAT RW1C; 5 IRQ_EN RW; 6,7 unmapped.
REQ-014 Reads of 1 and 2 SHALL return LED_OUT; unmapped reads SHALL return 0; unmapped and RO writes SHALL be ignored but acked.
REQ-015 Writes SHALL honour i_wb_sel per byte lane; bits of disabled lanes unchanged (for W1S/W1C/RW1C: treated as 0).
REQ-016 Register widths: LED_OUT NUM_LEDS; SW_IN, EDGE_STAT, IRQ_EN NUM_SW; unused read bits 0; unused write bits ignored.
REQ-017 A write SHALL take effect on the accept edge; a read in the next cycle returns the new value.
REQ-018 o_leds SHALL equal LED_OUT directly.
REQ-019 i_switches SHALL pass a 2-flop synchroniser; the second flop gives sw_sync.
REQ-020 A shared stability counter SHALL reset to 0 whenever sw_sync differs from its previous value, else increment, saturating at DEBOUNCE_CYCLES.
REQ-021 When the counter reaches DEBOUNCE_CYCLES-1 with sw_sync unchanged, SW_IN SHALL load sw_sync on that edge; counter saturates, no reload until next change.
REQ-022 Each SW_IN bit that changes value (either edge) SHALL set its EDGE_STAT bit on the same edge.
REQ-023 A same-cycle EDGE_STAT W1C and new edge on a bit: set SHALL win.
REQ-024 o_irq SHALL be registered: o_irq <= |(EDGE_STAT & IRQ_EN), using post-update values, so it rises one cycle after the status/enable change.
REQ-025 Total switch-to-SW_IN latency SHALL be 2 + DEBOUNCE_CYCLES cycles for a clean step.

Reset
REQ-026 On i_reset: LED_OUT, SW_IN, EDGE_STAT, IRQ_EN, counter, synchroniser flops = 0; o_wb_ack=0, o_wb_data=0, o_irq=0.
REQ-027 A request accepted in the reset cycle SHALL be discarded and not acked; reset mid-stream cancels a pending ack.
REQ-028 SW_IN load after reset SHALL not set EDGE_STAT for bits already 0 (only changes from reset value count).

Verification
REQ-029 Write 0x0000A5A5 to addr 0 sel=4'b0011, then read addr 0 -> ack each next cycle, o_leds=16'hA5A5, read data 0x0000A5A5.
REQ-030 With LED_OUT=0x00FF: write 0x0F00 to addr 1, then 0x000F to addr 2, pipelined back-to-back -> two consecutive acks, o_leds=0x0FF0.
REQ-031 DEBOUNCE_CYCLES=4: i_switches=0x0001 held -> SW_IN=0x0001 exactly 6 cycles later, EDGE_STAT bit0=1; glitch of 3 cycles -> SW_IN unchanged.
REQ-032 IRQ_EN=0x0001, edge on bit0 -> o_irq=1 one cycle after EDGE_STAT set; write 0x1 to addr 4 -> o_irq=0 next cycle; W1C coinciding with new edge -> bit stays 1.
REQ-033 Read addr 6 -> ack with data 0; write addr 3 -> ack, SW_IN unchanged; drop i_wb_cyc in ack cycle -> no ack.
REQ-034 Assert i_reset mid-burst with LED_OUT=0xFFFF -> o_leds=0, no pending ack, o_irq=0 next cycle.

Source files
------------

// File: rtl/wb_gpio_bank_if.sv
// Pipelined Wishbone slave bus bundle for wb_gpio_bank.
// Signal names keep the i_/o_ prefixes as seen from the slave.
interface wb_gpio_bank_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [29:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: LED output register with set/clear aliases, debounced
// switch inputs with sticky edge status and a level interrupt.
module wb_gpio_bank #(
    parameter int NUM_LEDS        = 16,
    parameter int NUM_SW          = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    wb_gpio_bank_if.slave       wb,
    input  logic [NUM_SW-1:0]   i_switches,
    output logic [NUM_LEDS-1:0] o_leds,
    output logic                o_irq
);

    typedef enum logic [2:0] {
        ADDR_LED_OUT   = 3'd0,
        ADDR_LED_SET   = 3'd1,
        ADDR_LED_CLR   = 3'd2,
        ADDR_SW_IN     = 3'd3,
        ADDR_EDGE_STAT = 3'd4,
        ADDR_IRQ_EN    = 3'd5,
        ADDR_RSVD6     = 3'd6,
        ADDR_RSVD7     = 3'd7
    } reg_addr_e;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic                ack_q,    ack_d;
    logic [31:0]         rdata_q,  rdata_d;
    logic [NUM_LEDS-1:0] led_q,    led_d;
    logic [NUM_SW-1:0]   irq_en_q, irq_en_d;
    logic [NUM_SW-1:0]   edge_q,   edge_d;
    logic [NUM_SW-1:0]   sw_in_q,  sw_in_d;
    logic [NUM_SW-1:0]   sync1_q,  sync1_d;
    logic [NUM_SW-1:0]   sync2_q,  sync2_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic                irq_q,    irq_d;

    logic                accept;
    logic                wr;
    reg_addr_e           addr;
    logic [31:0]         lane_mask;
    logic [31:0]         wbits;
    logic [NUM_SW-1:0]   w1c;
    logic [NUM_SW-1:0]   edge_set;
    logic                sw_changed;
    logic                sw_load;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    always_comb begin
        accept    = wb.i_wb_cyc & wb.i_wb_stb;
        wr        = accept & wb.i_wb_we;
        addr      = reg_addr_e'(wb.i_wb_addr[2:0]);
        lane_mask = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
                     {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
        wbits     = wb.i_wb_data & lane_mask;

        led_d    = led_q;
        irq_en_d = irq_en_q;
        w1c      = '0;
        if (wr) begin
            case (addr)
                ADDR_LED_OUT:   led_d = (led_q & ~lane_mask[NUM_LEDS-1:0]) | wbits[NUM_LEDS-1:0];
                ADDR_LED_SET:   led_d = led_q | wbits[NUM_LEDS-1:0];
                ADDR_LED_CLR:   led_d = led_q & ~wbits[NUM_LEDS-1:0];
                ADDR_EDGE_STAT: w1c   = wbits[NUM_SW-1:0];
                ADDR_IRQ_EN:    irq_en_d = (irq_en_q & ~lane_mask[NUM_SW-1:0]) | wbits[NUM_SW-1:0];
                default:        ;
            endcase
        end

        // Counter restarts on the same edge the synchroniser output moves,
        // so a clean step reaches SW_IN 2 + DEBOUNCE_CYCLES edges later.
        sync1_d    = i_switches;
        sync2_d    = sync1_q;
        sw_changed = (sync2_d != sync2_q);
        if (sw_changed)          cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        else                     cnt_d = cnt_q;
        sw_load  = !sw_changed && (cnt_q == CNT_LOAD);
        sw_in_d  = sw_load ? sync2_q : sw_in_q;
        edge_set = sw_in_d ^ sw_in_q;
        edge_d   = (edge_q & ~w1c) | edge_set;

        irq_d = |(edge_q & irq_en_q);

        case (addr)
            ADDR_LED_OUT, ADDR_LED_SET, ADDR_LED_CLR: rd_mux = 32'(led_q);
            ADDR_SW_IN:     rd_mux = 32'(sw_in_q);
            ADDR_EDGE_STAT: rd_mux = 32'(edge_q);
            ADDR_IRQ_EN:    rd_mux = 32'(irq_en_q);
            default:        rd_mux = '0;
        endcase
        ack_d   = accept;
        rdata_d = accept ? rd_mux : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            led_q    <= '0;
            irq_en_q <= '0;
            edge_q   <= '0;
            sw_in_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            irq_en_q <= irq_en_d;
            edge_q   <= edge_d;
            sw_in_q  <= sw_in_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    // Dropping cyc in the ack cycle abandons the response.
    assign wb.o_wb_ack   = ack_q & wb.i_wb_cyc;
    assign wb.o_wb_data  = (ack_q & wb.i_wb_cyc) ? rdata_q : '0;
    assign wb.o_wb_stall = 1'b0;
    assign o_leds        = led_q;
    assign o_irq         = irq_q;

    assign unused_bits = ^{wb.i_wb_addr[29:3], lane_mask, wbits};

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed self-checking bench for wb_gpio_bank with DEBOUNCE_CYCLES=4.
module tb_wb_gpio_bank;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_switches;
    logic [15:0] o_leds;
    logic        o_irq;
    int          checks   = 0;
    int          failures = 0;

    wb_gpio_bank_if bus ();

    wb_gpio_bank #(
        .NUM_LEDS(16),
        .NUM_SW(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .wb(bus),
        .i_switches(i_switches),
        .o_leds(o_leds),
        .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        bus.i_wb_sel  = s;
        tick();
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        #1;
        check({tag, "_ack"}, 32'(bus.o_wb_ack), 32'd1);
        bus.i_wb_cyc = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [29:0] a, input logic [31:0] exp, input string tag);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = a;
        bus.i_wb_sel  = 4'hF;
        tick();
        bus.i_wb_stb = 1'b0;
        #1;
        check({tag, "_ack"}, 32'(bus.o_wb_ack), 32'd1);
        check({tag, "_data"}, bus.o_wb_data, exp);
        bus.i_wb_cyc = 1'b0;
        tick();
    endtask

    initial begin
        i_reset       = 1'b1;
        i_switches    = '0;
        bus.i_wb_cyc  = 1'b0;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = '0;
        bus.i_wb_data = '0;
        bus.i_wb_sel  = '0;
        tick();

        // request presented in the reset cycle must vanish
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_data = 32'h0000FFFF;
        bus.i_wb_sel  = 4'hF;
        tick();
        check("rst_leds", 32'(o_leds), 32'h0);
        check("rst_ack", 32'(bus.o_wb_ack), 32'h0);
        check("rst_data", bus.o_wb_data, 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        check("stall", 32'(bus.o_wb_stall), 32'h0);
        i_reset      = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        tick();
        check("rst_req_dropped_ack", 32'(bus.o_wb_ack), 32'h0);
        check("rst_req_dropped_leds", 32'(o_leds), 32'h0);
        bus.i_wb_cyc = 1'b0;
        repeat (8) tick();

        // byte-lane writes and readback
        wb_write(30'd0, 32'h0000A5A5, 4'b0011, "led_wr");
        check("led_a5a5", 32'(o_leds), 32'h0000A5A5);
        wb_read(30'd0, 32'h0000A5A5, "led_rd");
        wb_write(30'd0, 32'h12345678, 4'b0001, "led_lane0");
        check("led_lane0_val", 32'(o_leds), 32'h0000A578);
        wb_write({27'h5, 3'd0}, 32'h000000FF, 4'hF, "led_hiaddr");
        check("led_00ff", 32'(o_leds), 32'h000000FF);

        // pipelined set then clear
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_sel  = 4'hF;
        bus.i_wb_addr = 30'd1;
        bus.i_wb_data = 32'h00000F00;
        tick();
        check("pipe_ack0", 32'(bus.o_wb_ack), 32'd1);
        check("pipe_leds0", 32'(o_leds), 32'h00000FFF);
        bus.i_wb_addr = 30'd2;
        bus.i_wb_data = 32'h0000000F;
        tick();
        check("pipe_ack1", 32'(bus.o_wb_ack), 32'd1);
        check("pipe_leds1", 32'(o_leds), 32'h00000FF0);
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        tick();
        check("pipe_ack_end", 32'(bus.o_wb_ack), 32'd0);
        bus.i_wb_cyc = 1'b0;
        wb_read(30'd1, 32'h00000FF0, "rd_set_alias");
        wb_read(30'd2, 32'h00000FF0, "rd_clr_alias");

        // unmapped / read-only accesses
        wb_read(30'd6, 32'h0, "rd_unmapped6");
        wb_read(30'd7, 32'h0, "rd_unmapped7");
        wb_write(30'd3, 32'h0000FFFF, 4'hF, "wr_ro");
        wb_read(30'd3, 32'h0, "rd_sw_after_ro_wr");
        wb_write(30'd7, 32'h0000FFFF, 4'hF, "wr_unmapped");
        wb_read(30'd0, 32'h00000FF0, "rd_led_after_unmapped");

        // cyc dropped in ack cycle
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_addr = 30'd0;
        tick();
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        #1;
        check("cyc_drop_ack", 32'(bus.o_wb_ack), 32'd0);
        check("cyc_drop_data", bus.o_wb_data, 32'd0);
        tick();
        check("cyc_drop_later", 32'(bus.o_wb_ack), 32'd0);

        // debounce latency and interrupt
        wb_write(30'd5, 32'h00000001, 4'hF, "irq_en_wr");
        wb_read(30'd5, 32'h00000001, "irq_en_rd");
        i_switches = 16'h0001;
        repeat (5) tick();
        check("sw_in_t5", 32'(dut.sw_in_q), 32'h0);
        tick();
        check("sw_in_t6", 32'(dut.sw_in_q), 32'h1);
        check("irq_t6", 32'(o_irq), 32'd0);
        tick();
        check("irq_t7", 32'(o_irq), 32'd1);
        wb_read(30'd3, 32'h00000001, "rd_sw_in");
        wb_read(30'd4, 32'h00000001, "rd_edge");
        wb_write(30'd4, 32'h00000001, 4'hF, "edge_w1c");
        check("irq_after_w1c", 32'(o_irq), 32'd0);
        wb_read(30'd4, 32'h0, "rd_edge_cleared");

        // 3-cycle glitch is filtered
        i_switches = 16'h0000;
        repeat (3) tick();
        i_switches = 16'h0001;
        repeat (12) tick();
        wb_read(30'd3, 32'h00000001, "glitch_sw_in");
        wb_read(30'd4, 32'h0, "glitch_edge");
        check("glitch_irq", 32'(o_irq), 32'd0);

        // falling edge, then W1C landing on the same edge as a new rise
        i_switches = 16'h0000;
        repeat (8) tick();
        wb_read(30'd3, 32'h0, "fall_sw_in");
        wb_read(30'd4, 32'h00000001, "fall_edge");
        check("fall_irq", 32'(o_irq), 32'd1);
        i_switches = 16'h0001;
        repeat (5) tick();
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = 30'd4;
        bus.i_wb_data = 32'h00000001;
        bus.i_wb_sel  = 4'hF;
        tick();
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        check("coinc_ack", 32'(bus.o_wb_ack), 32'd1);
        check("coinc_load", 32'(dut.sw_in_q), 32'h1);
        bus.i_wb_cyc = 1'b0;
        tick();
        wb_read(30'd4, 32'h00000001, "coinc_edge");
        wb_write(30'd4, 32'h00000001, 4'b1110, "w1c_lane_off");
        wb_read(30'd4, 32'h00000001, "w1c_lane_off_edge");
        check("irq_pre_reset", 32'(o_irq), 32'd1);

        // reset in the middle of a burst
        wb_write(30'd0, 32'h0000FFFF, 4'hF, "led_ffff");
        check("led_ffff_val", 32'(o_leds), 32'h0000FFFF);
        i_switches    = 16'h0000;
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_addr = 30'd0;
        tick();
        check("burst_ack", 32'(bus.o_wb_ack), 32'd1);
        check("burst_data", bus.o_wb_data, 32'h0000FFFF);
        i_reset = 1'b1;
        tick();
        check("midrst_leds", 32'(o_leds), 32'h0);
        check("midrst_ack", 32'(bus.o_wb_ack), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        i_reset      = 1'b0;
        bus.i_wb_stb = 1'b0;
        tick();
        check("midrst_no_late_ack", 32'(bus.o_wb_ack), 32'd0);
        bus.i_wb_cyc = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
